mac_result_serializer: RTL and testbench

MAC_RESULT_SERIALIZER -- requirements
Module: mac_result_serializer

---
 rtl/mac_result_serializer_pkg.sv | 5 +
 rtl/mac_result_serializer.sv | 67 ++++++
 tb/tb_mac_result_serializer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mac_result_serializer_pkg.sv
// mac_result_serializer_pkg: shared MAC FSM states and default accumulator width
package mac_result_serializer_pkg;
   localparam int MAC_RES_W = 20;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/mac_result_serializer.sv
// mac_result_serializer: shifts a captured {carry, result} MAC frame out one bit per ready handshake
module mac_result_serializer
   import mac_result_serializer_pkg::*;
#(
   parameter int RES_W     = MAC_RES_W,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             finish,
   input  logic [RES_W-1:0] mac_res,
   input  logic             mac_carry,
   input  logic             ser_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_last,
   output logic             busy,
   output logic             done,
   output logic             overrun
);
   localparam int CW = $clog2(RES_W + 1);
   state_t state, state_nx;
   logic [RES_W:0] sreg;
   logic [CW-1:0] cnt;
   logic finish_q, armed, rise, xfer;
   // armed blocks a capture from a finish level already high when reset releases
   assign rise = finish & ~finish_q & armed;
   assign xfer = ser_valid & ser_ready;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = rise ? SHIFT : IDLE;
         SHIFT:   state_nx = (xfer && cnt == '0) ? DONE : SHIFT;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      ser_valid = state == SHIFT;
      ser_last  = ser_valid && cnt == '0;
      ser_out   = ser_valid & (MSB_FIRST ? sreg[RES_W] : sreg[0]);
      busy      = state != IDLE;
      done      = state == DONE;
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         sreg     <= '0;
         cnt      <= '0;
         finish_q <= 1'b0;
         armed    <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         finish_q <= finish;
         if (!finish) armed <= 1'b1;
         if (rise && state != IDLE) overrun <= 1'b1;
         if (state == IDLE && rise) begin
            // carry sits where the first shifted bit is taken from
            sreg <= MSB_FIRST ? {mac_carry, mac_res} : {mac_res, mac_carry};
            cnt  <= CW'(RES_W);
         end else if (xfer && cnt != '0) begin
            sreg <= MSB_FIRST ? sreg << 1 : sreg >> 1;
            cnt  <= cnt - 1'b1;
         end
      end
endmodule

// File: tb/tb_mac_result_serializer.sv
// tb_mac_result_serializer: directed frames on MSB-first and LSB-first instances, checked against a bit-order model
module tb_mac_result_serializer;
   logic clock = 1'b0, reset_n, finish, ser_ready, mac_carry;
   logic [19:0] mac_res;
   logic [1:0] s_out, s_valid, s_last, s_busy, s_done, s_ovr;
   int n_chk = 0, n_err = 0;

   always #5 clock = ~clock;

   mac_result_serializer #(.RES_W(20), .MSB_FIRST(1'b0)) dut_l (
      .clock(clock), .reset_n(reset_n), .finish(finish), .mac_res(mac_res), .mac_carry(mac_carry),
      .ser_ready(ser_ready), .ser_out(s_out[0]), .ser_valid(s_valid[0]), .ser_last(s_last[0]),
      .busy(s_busy[0]), .done(s_done[0]), .overrun(s_ovr[0]));
   mac_result_serializer #(.RES_W(20), .MSB_FIRST(1'b1)) dut_m (
      .clock(clock), .reset_n(reset_n), .finish(finish), .mac_res(mac_res), .mac_carry(mac_carry),
      .ser_ready(ser_ready), .ser_out(s_out[1]), .ser_valid(s_valid[1]), .ser_last(s_last[1]),
      .busy(s_busy[1]), .done(s_done[1]), .overrun(s_ovr[1]));

   // frame in arrival order: index 0 is the first bit on the wire
   function automatic logic [20:0] frame(input logic [19:0] r, input logic c, input bit msb);
      logic [20:0] f;
      f[0] = c;
      for (int i = 0; i < 20; i++) f[i+1] = msb ? r[19-i] : r[i];
      return f;
   endfunction

   logic [20:0] m_bits [2];
   int m_idx [2] = '{0, 0};
   bit m_act [2] = '{0, 0};
   bit m_done [2] = '{0, 0};
   bit m_ovr [2] = '{0, 0};
   bit m_pf = 0, m_armed = 0;
   wire m_rise = finish & ~m_pf & m_armed;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_pf <= 0;
         m_armed <= 0;
         for (int j = 0; j < 2; j++) begin
            m_act[j] <= 0; m_done[j] <= 0; m_ovr[j] <= 0; m_idx[j] <= 0;
         end
      end else begin
         for (int j = 0; j < 2; j++) begin
            if (m_rise && (m_act[j] || m_done[j])) m_ovr[j] <= 1;
            if (m_done[j]) m_done[j] <= 0;
            else if (m_act[j]) begin
               if (ser_ready) begin
                  if (m_idx[j] == 20) begin m_act[j] <= 0; m_done[j] <= 1; end
                  else m_idx[j] <= m_idx[j] + 1;
               end
            end else if (m_rise) begin
               m_bits[j] <= frame(mac_res, mac_carry, j == 1);
               m_idx[j] <= 0;
               m_act[j] <= 1;
            end
         end
         m_pf <= finish;
         if (!finish) m_armed <= 1;
      end
   end

   // received bits shift in, so the first bit ends up in bit 20
   logic [20:0] rec [2] = '{21'h0, 21'h0};
   int rec_n [2] = '{0, 0};
   int dn [2] = '{0, 0};
   int bcnt = 0;
   always @(negedge clock) begin
      for (int j = 0; j < 2; j++) begin
         if (s_valid[j] && ser_ready) begin
            rec[j] <= {rec[j][19:0], s_out[j]};
            rec_n[j] <= rec_n[j] + 1;
         end
         if (s_done[j]) dn[j] <= dn[j] + 1;
      end
      if (s_busy[1]) bcnt <= bcnt + 1;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      for (int j = 0; j < 2; j++) begin
         check($sformatf("valid%0d", j), s_valid[j], m_act[j]);
         check($sformatf("out%0d", j), s_out[j], m_act[j] ? m_bits[j][m_idx[j]] : 1'b0);
         check($sformatf("last%0d", j), s_last[j], m_act[j] && m_idx[j] == 20);
         check($sformatf("busy%0d", j), s_busy[j], m_act[j] || m_done[j]);
         check($sformatf("done%0d", j), s_done[j], m_done[j]);
         check($sformatf("overrun%0d", j), s_ovr[j], m_ovr[j]);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      while (s_busy != 2'b00 && k < 200) begin tick(1); k++; end
      check({nm, "_idle"}, k < 200, 1);
   endtask

   int b0, d0, c0;

   task automatic snap();
      b0 = rec_n[1]; d0 = dn[1]; c0 = bcnt;
   endtask

   task automatic frame_checks(input string nm, input logic [20:0] el, input logic [20:0] em);
      check({nm, "_rec_lsb"}, rec[0], el);
      check({nm, "_rec_msb"}, rec[1], em);
      check({nm, "_bits"}, rec_n[1] - b0, 21);
      check({nm, "_dones"}, dn[1] - d0, 1);
   endtask

   initial begin
      reset_n = 0; finish = 0; ser_ready = 1; mac_res = '0; mac_carry = 0;
      fork
         forever begin @(negedge clock); compare_all(); end
      join_none
      tick(3);
      check("reset_outputs", {s_out, s_valid, s_last, s_busy, s_done, s_ovr}, 0);
      reset_n = 1;
      tick(2);
      // carry-first MSB frame; inputs change right after capture
      snap();
      mac_res = 20'h80001; mac_carry = 1; finish = 1; tick(1);
      finish = 0; mac_res = 20'h7fffe; mac_carry = 0;
      wait_idle("t1");
      frame_checks("t1", 21'h180001, 21'h180001);
      check("t1_busy_cycles", bcnt - c0, 22);
      check("t1_overrun", s_ovr, 0);
      // same frame under a 1,0,0 ready pattern
      snap();
      mac_res = 20'h80001; mac_carry = 1; finish = 1; tick(1);
      finish = 0; mac_res = '0; mac_carry = 0;
      for (int c = 0; c < 300 && s_busy != 2'b00; c++) begin ser_ready = (c % 3 == 0); tick(1); end
      ser_ready = 1;
      wait_idle("t2");
      frame_checks("t2", 21'h180001, 21'h180001);
      // finish level held for 50 cycles
      snap();
      mac_res = 20'hA5A5A; mac_carry = 0; finish = 1; tick(50);
      finish = 0; tick(2);
      wait_idle("t3");
      frame_checks("t3", 21'h05A5A5, 21'h0A5A5A);
      check("t3_overrun", s_ovr, 0);
      // second rising edge mid-frame
      snap();
      mac_res = 20'h12345; mac_carry = 1; finish = 1; tick(1);
      finish = 0; mac_res = '0; mac_carry = 0; tick(5);
      finish = 1; tick(1);
      finish = 0;
      wait_idle("t4");
      tick(3);
      frame_checks("t4", 21'h1A2C48, 21'h112345);
      check("t4_overrun", s_ovr, 2'b11);
      // asynchronous reset mid-frame with finish still high
      snap();
      mac_res = 20'h55555; mac_carry = 0; finish = 1; tick(11);
      #2 reset_n = 0;
      #1 check("async_reset_outputs", {s_out, s_valid, s_last, s_busy, s_done, s_ovr}, 0);
      check("t5_no_done", dn[1] - d0, 0);
      tick(2);
      reset_n = 1;
      tick(5);
      check("t5_no_capture_after_reset", s_busy, 0);
      snap();
      finish = 0; tick(1);
      finish = 1; tick(1);
      finish = 0;
      wait_idle("t5");
      frame_checks("t5", 21'h0AAAAA, 21'h055555);
      check("t5_overrun", s_ovr, 0);
      // LSB-first order with a small result
      snap();
      mac_res = 20'h00003; mac_carry = 0; finish = 1; tick(1);
      finish = 0; mac_res = 20'hFFFFF;
      wait_idle("t6");
      frame_checks("t6", 21'h0C0000, 21'h000003);
      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
